router_port_rx: RTL and testbench
=================================

Name: router_port_rx

Overview:
Downstream consumer for one 8-bit output port of the 1x3 router (valid_out_x / read_enb_x / data_out_x).
- Drains a packet from the router output FIFO: header, then payload, then parity.
- Forwards header and payload bytes on a ready/valid sink stream with sop/eop markers.
- Checks the parity byte and reports per-packet status; three instances sit behind the router, one per port.

Parameters:
TIMEOUT, 32, consecutive starved cycles mid-packet before abort (legal range 2..255)
CNT_W, 16, width of statistics counters

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
valid_out  in  1  router port has data (FIFO not empty)
data_out  in  8  router port read data, valid the cycle after read_enb sampled high
read_enb  out  1  read strobe to router port
sink_valid  out  1  byte available on sink
sink_data  out  8  header/payload byte
sink_sop  out  1  marks header byte
sink_eop  out  1  marks last payload byte (header byte if length 0)
sink_ready  in  1  sink accepts byte when sink_valid and sink_ready are both high
pkt_done  out  1  1-cycle pulse when parity byte captured
parity_err  out  1  1-cycle pulse, coincident with pkt_done, on parity mismatch
pkt_abort  out  1  1-cycle pulse on timeout abort
pkt_addr  out  2  header[1:0] of current/last packet
pkt_cnt  out  CNT_W  good packets received
err_cnt  out  CNT_W  parity-error plus aborted packets

Behaviour:
- Reset (async, resetn=0): every output 0, FSM to IDLE, buffer emptied, all counters cleared. Applies immediately mid-packet; sink_valid drops without waiting for a clock.
- Read latency: a byte issued with read_enb at edge N is captured from data_out at edge N+1. An inflight flag tracks each outstanding read.
- Output buffer: 2-entry FIFO of {byte, sop, eop}.
  - Pop when sink_valid && sink_ready.
  - Header and payload reads may be issued only if occupancy + inflight - pop < 2.
  - The parity byte is never buffered, so its read needs no room.
- read_enb = valid_out && FSM permits && room. It never depends combinationally on data_out.
- Running parity = XOR of header and all payload bytes. The packet is good if the parity byte equals the running parity.
- FSM:
  - IDLE: read_enb when valid_out and room -> HDR.
  - HDR: no reads. Capture header; len = header[7:2], pkt_addr = header[1:0]; push header with sop=1, eop=(len==0). Set remaining = len + 1 (payload + parity) -> BODY.
  - BODY: issue reads until remaining reads have all been issued. The last payload byte is pushed with eop=1. On capturing the parity byte, pulse pkt_done (plus parity_err if mismatch) at the edge after capture -> IDLE.
- The one bubble cycle after the header read is intentional.
- Starvation: in BODY, a counter increments each cycle with valid_out=0 and no inflight read, and clears otherwise. At TIMEOUT: pulse pkt_abort and go to IDLE; no eop is forced. Bytes already buffered are still delivered. This covers the router soft-resetting a port FIFO.
- pkt_cnt increments on pkt_done && !parity_err. err_cnt increments on parity_err or pkt_abort. Both counters saturate at all-ones.
- Simultaneous push and pop on the buffer is legal: occupancy is unchanged and ordering is preserved.
- sink_data / sop / eop are held stable while sink_valid && !sink_ready.

Optional Feature:
RX_STATS_EN. Defined: pkt_cnt and err_cnt are implemented as above. Undefined: both are tied to 0 with no counter flops; all other behaviour is identical.

Test Plan:
- Len 4, addr 2 (header 0x12), 4 random payload bytes, correct parity, sink_ready=1 -> sink sees 5 bytes; sop on 0x12, eop on 4th payload; pkt_done 1 cycle after parity capture; parity_err=0; pkt_cnt=1; pkt_addr=2.
- Same packet with parity+1 -> pkt_done and parity_err pulse together; payload still forwarded; err_cnt=1 (RX_STATS_EN defined); pkt_cnt unchanged.
- Len 0, addr 1 (header 0x01, parity 0x01) -> single sink beat with sop=eop=1; pkt_done, no parity_err.
- Len 35 with sink_ready low for 10 cycles mid-packet -> read_enb low while buffer full; never more than 2 bytes held; 36 bytes delivered in order, none lost or duplicated.
- Valid_out drops after 3 payload bytes of a len-8 packet and stays low -> pkt_abort exactly 32 cycles later; FSM idle; the next len-4 packet is received cleanly with pkt_done.
- Resetn asserted mid-payload -> all outputs 0 immediately; after release, a fresh len-4 packet completes normally.

Source files
------------

// File: rtl/router_port_rx_if.sv
// Handshake bundle between one router output port, its receiver and the downstream sink.
// The slave modport is the receiver side; the master modport drives the router/sink side.
interface router_port_rx_if;
  logic       valid_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic       sink_valid;
  logic [7:0] sink_data;
  logic       sink_sop;
  logic       sink_eop;
  logic       sink_ready;

  modport master (
    output valid_out, data_out, sink_ready,
    input  read_enb, sink_valid, sink_data, sink_sop, sink_eop
  );

  modport slave (
    input  valid_out, data_out, sink_ready,
    output read_enb, sink_valid, sink_data, sink_sop, sink_eop
  );
endinterface

// File: rtl/router_port_rx.sv
// router_port_rx: drains one router output port into a sop/eop sink stream and checks packet parity.
// Build option RX_STATS_EN adds saturating good/error packet counters (tied to zero otherwise).
module router_port_rx #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  router_port_rx_if.slave  bus,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort,
  output logic [1:0]       pkt_addr,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] STARVE_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

  state_t     state;
  logic       inflight;
  logic [6:0] issue_left;
  logic [6:0] cap_left;
  logic [7:0] run_par;
  logic [7:0] starve;
  logic       done_pend;
  logic       err_pend;

  // Output buffer entries are {sop, eop, byte}
  logic [9:0] buf_mem [2];
  logic       buf_rd;
  logic       buf_wr;
  logic [1:0] buf_cnt;

  logic       pop;
  logic       push;
  logic [9:0] push_entry;
  logic       inflight_buf;
  logic       room;
  logic       rd_en;
  logic       starved;
  logic [2:0] occ_next;

  // Buffer room accounting and starvation detect
  always_comb begin
    pop          = (buf_cnt != 2'd0) && bus.sink_ready;
    inflight_buf = inflight && !((state == BODY) && (cap_left == 7'd1));
    occ_next     = {1'b0, buf_cnt} + {2'b00, inflight_buf} - {2'b00, pop};
    room         = (occ_next < 3'd2);
    starved      = (state == BODY) && !bus.valid_out && !inflight;
  end

  // Read strobe; the parity read bypasses the room check since it is never buffered
  always_comb begin
    rd_en = 1'b0;
    if (resetn && bus.valid_out) begin
      case (state)
        IDLE:    rd_en = room;
        BODY: begin
          if (issue_left == 7'd0) begin
            rd_en = 1'b0;
          end else if (issue_left == 7'd1) begin
            rd_en = 1'b1;
          end else begin
            rd_en = room;
          end
        end
        default: rd_en = 1'b0;
      endcase
    end else begin
      rd_en = 1'b0;
    end
  end

  // Buffer push decode for captured header and payload bytes
  always_comb begin
    push       = 1'b0;
    push_entry = 10'd0;
    if (inflight) begin
      case (state)
        HDR: begin
          push       = 1'b1;
          push_entry = {1'b1, (bus.data_out[7:2] == 6'd0), bus.data_out};
        end
        BODY: begin
          if (cap_left >= 7'd2) begin
            push       = 1'b1;
            push_entry = {1'b0, (cap_left == 7'd2), bus.data_out};
          end else begin
            push = 1'b0;
          end
        end
        default: push = 1'b0;
      endcase
    end else begin
      push = 1'b0;
    end
  end

  assign bus.read_enb   = rd_en;
  assign bus.sink_valid = (buf_cnt != 2'd0);
  assign bus.sink_sop   = buf_mem[buf_rd][9];
  assign bus.sink_eop   = buf_mem[buf_rd][8];
  assign bus.sink_data  = buf_mem[buf_rd][7:0];

  // Two-entry output buffer
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buf_mem[0] <= 10'd0;
      buf_mem[1] <= 10'd0;
      buf_rd     <= 1'b0;
      buf_wr     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[buf_wr] <= push_entry;
        buf_wr          <= ~buf_wr;
      end
      if (pop) begin
        buf_rd <= ~buf_rd;
      end
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Packet FSM with read tracking, parity check, starvation abort and status pulses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      issue_left <= 7'd0;
      cap_left   <= 7'd0;
      run_par    <= 8'd0;
      starve     <= 8'd0;
      done_pend  <= 1'b0;
      err_pend   <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_addr   <= 2'd0;
    end else begin
      inflight   <= rd_en;
      done_pend  <= 1'b0;
      err_pend   <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_done   <= done_pend;
      parity_err <= err_pend;
      case (state)
        IDLE: begin
          starve <= 8'd0;
          state  <= rd_en ? HDR : IDLE;
        end
        HDR: begin
          if (inflight) begin
            pkt_addr   <= bus.data_out[1:0];
            issue_left <= {1'b0, bus.data_out[7:2]} + 7'd1;
            cap_left   <= {1'b0, bus.data_out[7:2]} + 7'd1;
            run_par    <= bus.data_out;
            state      <= BODY;
          end else begin
            state <= IDLE;
          end
        end
        BODY: begin
          if (rd_en) begin
            issue_left <= issue_left - 7'd1;
          end
          if (inflight) begin
            cap_left <= cap_left - 7'd1;
            if (cap_left == 7'd1) begin
              done_pend <= 1'b1;
              err_pend  <= (bus.data_out != run_par);
              state     <= IDLE;
            end else begin
              run_par <= run_par ^ bus.data_out;
            end
          end
          // starved excludes inflight, so abort never collides with the parity capture above
          if (starved) begin
            if (starve == STARVE_LAST) begin
              pkt_abort <= 1'b1;
              starve    <= 8'd0;
              state     <= IDLE;
            end else begin
              starve <= starve + 8'd1;
            end
          end else begin
            starve <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_STATS_EN
  // Saturating good/error packet counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= {CNT_W{1'b0}};
      err_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pkt_done && !parity_err && (pkt_cnt != {CNT_W{1'b1}})) begin
        pkt_cnt <= pkt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((parity_err || pkt_abort) && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign pkt_cnt = {CNT_W{1'b0}};
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: directed packet table, abort and reset sequences,
// then randomized traffic checked against a packet-level reference model.
module tb_router_port_rx;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 16;
`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             resetn;
  logic             pkt_done, parity_err, pkt_abort;
  logic [1:0]       pkt_addr;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  router_port_rx_if bus();

  router_port_rx #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .bus(bus),
    .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort),
    .pkt_addr(pkt_addr), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  // Router FIFO content: kind 0 header, 1 payload, 2 parity
  typedef struct {
    logic [7:0] data;
    logic [1:0] kind;
    logic       sop;
    logic       eop;
    logic       bad;
    logic [1:0] addr;
  } rbyte_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    logic [7:0] hdr;
    bit         bad;
    int         stall;
    int         exp_beats;
    int         exp_err;
    logic [1:0] exp_addr;
    int         exp_pkt;
    int         exp_errc;
  } vec_t;

  rbyte_t     rq[$];
  beat_t      exp_q[$];
  int         checks = 0, failures = 0;
  int         cur_step = 0;
  int         done_due = -1, abort_due = -1, body_start = -1;
  bit         done_err;
  logic [1:0] done_addr;
  bit         in_body = 1'b0, prev_rd = 1'b0, hold_chk = 1'b0;
  logic [9:0] held_beat;
  int         starve = 0, held = 0;
  int         beats = 0, dones = 0, errs = 0, aborts = 0;
  int         m_pkt = 0, m_err = 0;
  int         last_rd = 0, abort_seen = 0;
  bit         rand_src = 1'b0, rand_ready = 1'b0;
  int         stall_lo = 0, stall_hi = 0;
  vec_t       vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at step %0d", name, act, exp, cur_step);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input bit bad);
    rbyte_t     b;
    logic [7:0] par;
    int         len;
    len = int'(hdr[7:2]);
    par = hdr;
    b.data = hdr; b.kind = 2'd0; b.sop = 1'b1; b.eop = (len == 0); b.bad = 1'b0; b.addr = hdr[1:0];
    rq.push_back(b);
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      par ^= b.data;
      b.kind = 2'd1; b.sop = 1'b0; b.eop = (i == len - 1);
      rq.push_back(b);
    end
    b.data = bad ? par + 8'd1 : par;
    b.kind = 2'd2; b.sop = 1'b0; b.eop = 1'b0; b.bad = bad;
    rq.push_back(b);
  endtask

  // One clock: sample and check at negedge, drive next inputs just after posedge
  task automatic step();
    logic       rd, acc;
    rbyte_t     b;
    beat_t      e;
    logic [7:0] nd;
    @(negedge clock);
    cur_step++;
    rd  = bus.read_enb;
    acc = bus.sink_valid && bus.sink_ready;
    nd  = 8'($urandom);
    if (hold_chk)
      check("sink_hold", {21'd0, bus.sink_valid, bus.sink_sop, bus.sink_eop, bus.sink_data},
            {21'd0, 1'b1, held_beat});
    hold_chk  = bus.sink_valid && !bus.sink_ready;
    held_beat = {bus.sink_sop, bus.sink_eop, bus.sink_data};

    check("pkt_done", 32'(pkt_done), 32'(cur_step == done_due));
    check("parity_err", 32'(parity_err), 32'(cur_step == done_due && done_err));
    check("pkt_abort", 32'(pkt_abort), 32'(cur_step == abort_due));
    if (cur_step == done_due) check("pkt_addr_at_done", 32'(pkt_addr), 32'(done_addr));
    if (pkt_done) begin dones++; if (parity_err) errs++; end
    if (pkt_abort) begin aborts++; abort_seen = cur_step; end

    if (acc) begin
      check("sink_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sink_beat", {22'd0, bus.sink_sop, bus.sink_eop, bus.sink_data}, {22'd0, e});
      end
      beats++;
      held--;
    end

    if (cur_step == body_start) in_body = 1'b1;
    if (in_body) begin
      if (!bus.valid_out && !prev_rd) starve++;
      else starve = 0;
      if (starve == TIMEOUT) begin
        abort_due = cur_step + 1;
        in_body   = 1'b0;
        starve    = 0;
        m_err++;
      end
    end

    if (rd) begin
      check("read_gated", 32'(bus.valid_out), 32'd1);
      last_rd = cur_step;
      if (rq.size() > 0) begin
        b  = rq.pop_front();
        nd = b.data;
        case (b.kind)
          2'd0: begin body_start = cur_step + 2; exp_q.push_back({b.sop, b.eop, b.data}); held++; end
          2'd1: begin exp_q.push_back({b.sop, b.eop, b.data}); held++; end
          default: begin
            in_body   = 1'b0;
            done_due  = cur_step + 3;
            done_err  = b.bad;
            done_addr = b.addr;
            if (b.bad) m_err++; else m_pkt++;
          end
        endcase
      end
    end
    check("occupancy_le2", 32'(held <= 2), 32'd1);
    prev_rd = rd;

    @(posedge clock);
    #1;
    bus.data_out   = nd;
    bus.valid_out  = (rq.size() > 0) && (!rand_src || ($urandom_range(0, 4) != 0));
    bus.sink_ready = rand_ready ? 1'($urandom) : !(cur_step >= stall_lo && cur_step < stall_hi);
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((rq.size() > 0 || exp_q.size() > 0 || in_body || cur_step < done_due ||
            cur_step < abort_due) && n < budget) begin
      step();
      n++;
    end
    check("drain_budget", 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_cnt(input string name, input int exp_p, input int exp_e);
    check({name, "_pkt_cnt"}, 32'(pkt_cnt), STATS ? 32'(exp_p) : 32'd0);
    check({name, "_err_cnt"}, 32'(err_cnt), STATS ? 32'(exp_e) : 32'd0);
  endtask

  initial begin
    vt[0] = '{8'h12, 1'b0, 0,  5,  0, 2'd2, 1, 0};
    vt[1] = '{8'h12, 1'b1, 0,  5,  1, 2'd2, 1, 1};
    vt[2] = '{8'h01, 1'b0, 0,  1,  0, 2'd1, 2, 1};
    vt[3] = '{8'h8F, 1'b0, 10, 36, 0, 2'd3, 3, 1};

    resetn         = 1'b0;
    bus.valid_out  = 1'b0;
    bus.data_out   = 8'd0;
    bus.sink_ready = 1'b0;
    #1;
    check("rst_read_enb", 32'(bus.read_enb), 32'd0);
    check("rst_sink_valid", 32'(bus.sink_valid), 32'd0);
    check("rst_sink_bits", {22'd0, bus.sink_sop, bus.sink_eop, bus.sink_data}, 32'd0);
    check("rst_pulses", {29'd0, pkt_done, parity_err, pkt_abort}, 32'd0);
    check("rst_pkt_addr", 32'(pkt_addr), 32'd0);
    check_cnt("rst", 0, 0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    bus.sink_ready = 1'b1;

    // Directed packet table
    for (int i = 0; i < 4; i++) begin
      beats = 0; dones = 0; errs = 0;
      stall_lo = cur_step + 8;
      stall_hi = stall_lo + vt[i].stall;
      send_pkt(vt[i].hdr, vt[i].bad);
      run_idle(600);
      check("tbl_beats", 32'(beats), 32'(vt[i].exp_beats));
      check("tbl_done", 32'(dones), 32'd1);
      check("tbl_err", 32'(errs), 32'(vt[i].exp_err));
      check("tbl_addr", 32'(pkt_addr), 32'(vt[i].exp_addr));
      check_cnt("tbl", vt[i].exp_pkt, vt[i].exp_errc);
    end

    // Starvation: len 8 packet whose source dries up after 3 payload bytes
    aborts = 0; dones = 0;
    send_pkt(8'h20, 1'b0);
    repeat (6) void'(rq.pop_back());
    run_idle(200);
    check("abort_count", 32'(aborts), 32'd1);
    check("abort_latency", 32'(abort_seen - last_rd), 32'd34);
    check("abort_no_done", 32'(dones), 32'd0);
    dones = 0;
    send_pkt(8'h11, 1'b0);
    run_idle(200);
    check("post_abort_done", 32'(dones), 32'd1);
    check_cnt("post_abort", 4, 2);

    // Asynchronous reset in the middle of a payload
    send_pkt(8'h13, 1'b0);
    repeat (6) step();
    resetn = 1'b0;
    #2;
    check("mid_rst_read_enb", 32'(bus.read_enb), 32'd0);
    check("mid_rst_sink_valid", 32'(bus.sink_valid), 32'd0);
    check("mid_rst_sink_bits", {22'd0, bus.sink_sop, bus.sink_eop, bus.sink_data}, 32'd0);
    check("mid_rst_pulses", {29'd0, pkt_done, parity_err, pkt_abort}, 32'd0);
    check("mid_rst_pkt_addr", 32'(pkt_addr), 32'd0);
    check_cnt("mid_rst", 0, 0);
    rq.delete(); exp_q.delete();
    done_due = -1; abort_due = -1; body_start = -1;
    in_body = 1'b0; prev_rd = 1'b0; hold_chk = 1'b0;
    starve = 0; held = 0; m_pkt = 0; m_err = 0;
    bus.valid_out = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    dones = 0;
    send_pkt(8'h12, 1'b0);
    run_idle(200);
    check("post_rst_done", 32'(dones), 32'd1);
    check("post_rst_addr", 32'(pkt_addr), 32'd2);
    check_cnt("post_rst", 1, 0);

    // Randomized traffic with source gaps and sink backpressure
    rand_src = 1'b1; rand_ready = 1'b1;
    dones = 0; errs = 0;
    begin
      int n_bad;
      n_bad = 0;
      for (int p = 0; p < 25; p++) begin
        bit bad;
        bad = ($urandom_range(0, 3) == 0);
        if (bad) n_bad++;
        send_pkt({6'($urandom_range(0, 20)), 2'($urandom)}, bad);
      end
      run_idle(8000);
      check("rand_dones", 32'(dones), 32'd25);
      check("rand_errs", 32'(errs), 32'(n_bad));
    end
    check_cnt("rand", m_pkt, m_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
